sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO: the next generation of the team's 8x8 synchronous FIFO, generalised in data width and depth. It adds programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, legal simultaneous read/write at full, and sticky overflow/underflow error flags. It sits between any producer/consumer pair in the same clock domain, for example packet staging ahead of a serialiser.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_mem_2p.sv | 21 ++
 rtl/sync_fifo_param.sv | 72 +++++++
 tb/tb_sync_fifo_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the FIFO family
package fifo_pkg;
  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int FIFO_MODE_STD = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p: storage array with synchronous write and asynchronous read
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AW = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  assign rdata = mem[raddr];
  // write port; contents are deliberately left unreset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, FWFT mode and sticky errors
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = FIFO_MODE_STD
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 rd_en,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [clog2(DEPTH):0] count,
  input  logic                 err_clr,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] head;
  logic rd_acc, wr_acc;
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);
  fifo_mem_2p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .we(wr_acc), .waddr(wr_ptr), .wdata(wr_data), .raddr(rd_ptr), .rdata(head)
  );
  // pointers, occupancy and sticky error flags; a new error beats err_clr
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count <= (wr_acc && !rd_acc) ? count + CW'(1) : (rd_acc && !wr_acc) ? count - CW'(1) : count;
      overflow <= (wr_en && !wr_acc) || (overflow && !err_clr);
      underflow <= (rd_en && empty) || (underflow && !err_clr);
    end
  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rd_data = head;
      assign rd_valid = !empty;
    end else begin : g_std
      // registered read stage: capture the head word on each accepted pop
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          rd_data <= '0;
          rd_valid <= 1'b0;
        end else begin
          if (rd_acc) rd_data <= head;
          rd_valid <= rd_acc;
        end
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed checks of the standard and FWFT FIFO variants
module tb_sync_fifo_param;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] rd_data_a, rd_data_b;
  logic rd_valid_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
  logic rd_valid_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
  logic [4:0] count_a, count_b;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_a), .rd_valid(rd_valid_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .count(count_a), .err_clr(err_clr),
    .overflow(ov_a), .underflow(un_a)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_b), .rd_valid(rd_valid_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .count(count_b), .err_clr(err_clr),
    .overflow(ov_b), .underflow(un_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    chk("rst_count", 32'(count_a), 0);
    chk("rst_empty", 32'(empty_a), 1);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_ae", 32'(ae_a), 1);
    chk("rst_af", 32'(af_a), 0);
    chk("rst_valid", 32'(rd_valid_a), 0);
    chk("rst_data", 32'(rd_data_a), 0);
    chk("rst_ov", 32'(ov_a), 0);
    chk("rst_valid_fwft", 32'(rd_valid_b), 0);
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1;
      wr_data = 8'(i);
      step();
      chk("fill_count", 32'(count_a), 32'(i + 1));
      chk("fill_af", 32'(af_a), 32'(i + 1 >= 14));
      chk("fill_ae", 32'(ae_a), 32'(i + 1 <= 2));
    end
    chk("full", 32'(full_a), 1);
    wr_data = 8'hEE;
    step();
    wr_en = 0;
    chk("ovf_set", 32'(ov_a), 1);
    chk("ovf_count", 32'(count_a), 16);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      step();
      chk("drain_data", 32'(rd_data_a), 32'(i));
      chk("drain_valid", 32'(rd_valid_a), 1);
    end
    chk("drain_empty", 32'(empty_a), 1);
    step();
    rd_en = 0;
    chk("unf_set", 32'(un_a), 1);
    chk("unf_hold", 32'(rd_data_a), 32'h0F);
    chk("unf_valid", 32'(rd_valid_a), 0);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("clr_ov", 32'(ov_a), 0);
    chk("clr_un", 32'(un_a), 0);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1;
      wr_data = 8'(8'h40 + i);
      step();
    end
    chk("refill_full", 32'(full_a), 1);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1;
      rd_en = 1;
      wr_data = 8'(8'h50 + k);
      step();
      chk("wrap_data", 32'(rd_data_a), k < 16 ? 32'(8'h40 + k) : 32'(8'h50 + k - 16));
      chk("wrap_count", 32'(count_a), 16);
    end
    rd_en = 0;
    chk("wrap_no_ov", 32'(ov_a), 0);
    err_clr = 1;
    step();
    wr_en = 0;
    err_clr = 0;
    chk("clr_vs_set", 32'(ov_a), 1);
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1;
      wr_data = 8'(8'h10 + i);
      step();
    end
    wr_en = 0;
    chk("pre_rst_count", 32'(count_a), 5);
    rd_en = 1;
    step();
    rd_en = 0;
    wr_en = 1;
    wr_data = 8'hFF;
    step();
    wr_en = 0;
    chk("pre_rst_ov", 32'(ov_a), 0);
    wr_en = 1;
    for (int i = 0; i < 12; i++) step();
    wr_en = 0;
    chk("pre_rst_ov2", 32'(ov_a), 1);
    #2 rst = 1;
    #1;
    chk("arst_count", 32'(count_a), 0);
    chk("arst_empty", 32'(empty_a), 1);
    chk("arst_valid", 32'(rd_valid_a), 0);
    chk("arst_data", 32'(rd_data_a), 0);
    chk("arst_ov", 32'(ov_a), 0);
    chk("arst_valid_fwft", 32'(rd_valid_b), 0);
    step();
    rst = 0;
    wr_en = 1;
    wr_data = 8'h3C;
    step();
    wr_en = 0;
    chk("post_rst_count", 32'(count_a), 1);
    rd_en = 1;
    step();
    rd_en = 0;
    chk("post_rst_data", 32'(rd_data_a), 32'h3C);
    chk("post_rst_valid", 32'(rd_valid_a), 1);
    chk("fwft_empty", 32'(empty_b), 1);
    chk("fwft_idle_valid", 32'(rd_valid_b), 0);
    wr_en = 1;
    wr_data = 8'hA5;
    step();
    wr_en = 0;
    chk("fwft_valid", 32'(rd_valid_b), 1);
    chk("fwft_data", 32'(rd_data_b), 32'hA5);
    step();
    chk("fwft_hold", 32'(rd_data_b), 32'hA5);
    rd_en = 1;
    step();
    rd_en = 0;
    chk("fwft_pop_empty", 32'(empty_b), 1);
    chk("fwft_pop_valid", 32'(rd_valid_b), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
